// File: rtl/alu_pkg.sv
// Shared constants for the ALU and the sequential multiplier.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // op[2] inverts b and supplies the carry-in; op[1:0] selects the function.
  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;
  localparam logic [2:0] ALU_OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_32bit.sv
// 32-bit ALU: and/or, add/sub and signed set-less-than.
module alu_32bit
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] r,
  output logic        c_out
);

  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        slt;

  assign b_eff = op[2] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'd0, op[2]};
  assign c_out = sum[32];
  // Signs differ: a is less iff a is negative; otherwise the difference sign decides.
  assign slt   = (a[31] ^ b[31]) ? a[31] : sum[31];

  // Result select
  always_comb begin
    r = 32'd0;
    unique case (op[1:0])
      2'b00:   r = a & b_eff;
      2'b01:   r = a | b_eff;
      2'b10:   r = sum[31:0];
      default: r = {31'd0, slt};
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 shift-and-add multiplier driving alu_32bit as its adder.
// Optional macro ALU_MUL_SEQ_SIGNED_EN adds an is_signed port and radix-2 Booth mode.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::DEFAULT_WIDTH,  // only 32 is supported
  parameter int unsigned CNT_W = 6                         // 2**CNT_W must exceed WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef ALU_MUL_SEQ_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic               qm1_q, qm1_d;
  logic               sgn_q, sgn_d;
`endif

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  // {C,A} after the conditional add; C is only a carry into the shift, so it is
  // never stored: after the right shift it would always be zero (or the sign).
  logic [WIDTH:0]   ca;

  alu_32bit u_alu (
    .a     (a_q),
    .b     (m_q),
    .op    (alu_op),
    .r     (alu_r),
    .c_out (alu_c)
  );

  // ALU opcode: subtract only for the Booth 10 pair, add otherwise
  always_comb begin
    alu_op = ALU_OP_ADD;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    if (state_q == StCalc && sgn_q && q_q[0] && !qm1_q) alu_op = ALU_OP_SUB;
`endif
  end

  // Next-state, accumulate/shift and product capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    ca      = {1'b0, a_q};
`ifdef ALU_MUL_SEQ_SIGNED_EN
    qm1_d   = qm1_q;
    sgn_d   = sgn_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCalc;
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          cnt_d   = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
          qm1_d   = 1'b0;
          sgn_d   = is_signed;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        ca = q_q[0] ? {alu_c, alu_r} : {1'b0, a_q};
`ifdef ALU_MUL_SEQ_SIGNED_EN
        // Booth: top bit of ca carries the sign so the shift below is arithmetic
        if (sgn_q) begin
          case ({q_q[0], qm1_q})
            2'b01, 2'b10: ca = {alu_r[WIDTH-1], alu_r};
            default:      ca = {a_q[WIDTH-1], a_q};
          endcase
        end
        qm1_d = q_q[0];
`endif
        a_d   = ca[WIDTH:1];
        q_d   = {ca[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
          prod_d  = {a_d, q_d};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      qm1_q   <= 1'b0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      qm1_q   <= qm1_d;
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign ready   = (state_q == StIdle) || (state_q == StDone);
  assign busy    = (state_q == StCalc);
  assign done    = (state_q == StDone);
  assign product = prod_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: vector table plus multi-cycle corner sequences.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        sgn = 1'b0;
  logic        ready, busy, done;
  logic [63:0] product;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] m;
    logic [31:0] q;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ready        (ready),
    .multiplicand (mcand),
    .multiplier   (mplier),
`ifdef ALU_MUL_SEQ_SIGNED_EN
    .is_signed    (sgn),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (signed=%0b)", name, act, exp, sgn);
    end
  endtask

  // Counts negedges from the accept edge until done; lat=33 is the expected latency.
  task automatic wait_done(output int lat, output int busy_cnt, output bit ready_bad);
    lat = 0;
    busy_cnt = 0;
    ready_bad = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (busy && ready) ready_bad = 1'b1;
      if (done) break;
    end
    if (!done) lat = 999;
  endtask

  task automatic launch(input logic [31:0] m, input logic [31:0] q, input logic s);
    @(negedge clk);
    mcand = m;
    mplier = q;
    sgn = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bc, lat2;
    bit rb;
    int dones;
    logic [63:0] first;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    vecs.push_back('{"3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F});
    vecs.push_back('{"max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{"zero_x", 32'd0, 32'h1234_5678, 1'b0, 64'd0});
    vecs.push_back('{"one_x_max", 32'd1, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{"msb_x_2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000});
    vecs.push_back('{"shift16", 32'h1234_5678, 32'h10, 1'b0, 64'h0000_0001_2345_6780});
    vecs.push_back('{"max_x_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE});
    vecs.push_back('{"neg3x7_unsigned", 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB});
`ifdef ALU_MUL_SEQ_SIGNED_EN
    vecs.push_back('{"neg3x7_signed", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{"neg1xneg1_signed", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1});
    vecs.push_back('{"5xneg4_signed", 32'd5, 32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC});
    vecs.push_back('{"3x5_signed", 32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i].m, vecs[i].q, vecs[i].s);
      wait_done(lat, bc, rb);
      check({vecs[i].name, "_product"}, product, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
      check({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd32);
      check({vecs[i].name, "_ready_in_calc"}, 64'(rb), 64'd0);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
      check({vecs[i].name, "_held"}, product, vecs[i].exp);
    end

    // start re-asserted mid-CALC must be ignored
    launch(32'd6, 32'd4, 1'b0);
    lat = 0;
    rb = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      lat++;
      if (busy && ready) rb = 1'b1;
      if (lat == 10) begin
        mcand = 32'd7;
        mplier = 32'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    check("ignore_start_product", product, 64'h18);
    check("ignore_start_latency", 64'(lat), 64'd33);
    check("ignore_start_ready", 64'(rb), 64'd0);
    @(negedge clk);
    check("ignore_start_idle", 64'(busy), 64'd0);

    // Asynchronous reset in CALC cycle 12 aborts without a done pulse
    launch(32'd9, 32'd9, 1'b0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    launch(32'd2, 32'd2, 1'b0);
    wait_done(lat, bc, rb);
    check("after_abort_product", product, 64'd4);
    check("after_abort_latency", 64'(lat), 64'd33);

    // Back-to-back: start held in the DONE cycle
    launch(32'h1_0000, 32'h1_0000, 1'b0);
    wait_done(lat, bc, rb);
    first = product;
    check("b2b_first_product", first, 64'h0000_0001_0000_0000);
    mcand = 32'd3;
    mplier = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat2 = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      lat2++;
      if (lat2 == 1) check("b2b_no_idle", 64'(busy), 64'd1);
      if (lat2 == 5) check("b2b_product_held", product, 64'h0000_0001_0000_0000);
      if (done) break;
    end
    check("b2b_second_latency", 64'(lat2), 64'd33);
    check("b2b_second_product", product, 64'h0000_0000_0000_000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
